// File: rtl/usb_tx_arbiter.sv
// Round-robin arbiter that shares the USB transmit byte path between two packet sources.
// The granted packet is captured into a local buffer and streamed out one byte per take.
module usb_tx_arbiter #(
  parameter int NUM_BYTES = 66
) (
  input  logic                   i_clk,
  input  logic                   i_n_rst,
  input  logic                   i_req_a,
  input  logic [8*NUM_BYTES-1:0] i_pkt_a,
  input  logic                   i_req_b,
  input  logic [8*NUM_BYTES-1:0] i_pkt_b,
  input  logic                   i_tx_take,
  output logic                   o_ack_a,
  output logic                   o_ack_b,
  output logic [7:0]             o_tx_byte,
  output logic                   o_tx_valid,
  output logic                   o_tx_last,
  output logic                   o_done_a,
  output logic                   o_done_b,
  output logic                   o_busy
);

  localparam int CNT_W = $clog2(NUM_BYTES);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_owner;
  logic                   r_rr_ptr;
  logic [CNT_W-1:0]       r_byte_cnt;
  logic [8*NUM_BYTES-1:0] r_buffer;
  logic                   w_grant_b;
  logic                   w_last;

  // owner/rr_ptr encoding: 0 = source A, 1 = source B
  assign w_grant_b = i_req_b & (~i_req_a | r_rr_ptr);
  assign w_last    = (r_byte_cnt == CNT_W'(NUM_BYTES - 1));

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_req_a | i_req_b) w_next_state = LOAD;
      LOAD:    w_next_state = SEND;
      SEND:    if (i_tx_take && w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The buffer decouples the source: it may change its packet as soon as ack is seen.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_owner    <= 1'b0;
      r_rr_ptr   <= 1'b0;
      r_byte_cnt <= '0;
      r_buffer   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_a | i_req_b) r_owner <= w_grant_b;
        end
        LOAD: begin
          r_buffer   <= r_owner ? i_pkt_b : i_pkt_a;
          r_byte_cnt <= '0;
          r_rr_ptr   <= ~r_owner;
        end
        SEND: begin
          if (i_tx_take && !w_last) r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state, so tx_take never reaches tx_byte/tx_valid combinationally.
  always_comb begin
    o_ack_a    = 1'b0;
    o_ack_b    = 1'b0;
    o_tx_byte  = 8'h00;
    o_tx_valid = 1'b0;
    o_tx_last  = 1'b0;
    o_done_a   = 1'b0;
    o_done_b   = 1'b0;
    o_busy     = (r_state != IDLE);
    case (r_state)
      LOAD: begin
        o_ack_a = ~r_owner;
        o_ack_b = r_owner;
      end
      SEND: begin
        o_tx_valid = 1'b1;
        o_tx_byte  = r_buffer[{r_byte_cnt, 3'b000} +: 8];
        o_tx_last  = w_last;
      end
      DONE: begin
        o_done_a = ~r_owner;
        o_done_b = r_owner;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Scoreboard bench for usb_tx_arbiter: stimulus queues expected bytes/acks/dones,
// a negedge monitor pops and compares them whenever the DUT presents them.
module tb_usb_tx_arbiter;

  localparam int NB = 66;

  logic            clk;
  logic            nRst;
  logic            reqA;
  logic [8*NB-1:0] pktA;
  logic            reqB;
  logic [8*NB-1:0] pktB;
  logic            txTake;
  logic            ackA;
  logic            ackB;
  logic [7:0]      txByte;
  logic            txValid;
  logic            txLast;
  logic            doneA;
  logic            doneB;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  logic [8:0] expByte[$];
  logic       expAck[$];
  logic       expDone[$];
  logic       doneArmed = 1'b0;

  usb_tx_arbiter #(.NUM_BYTES(NB)) dut (
    .i_clk      (clk),
    .i_n_rst    (nRst),
    .i_req_a    (reqA),
    .i_pkt_a    (pktA),
    .i_req_b    (reqB),
    .i_pkt_b    (pktB),
    .i_tx_take  (txTake),
    .o_ack_a    (ackA),
    .o_ack_b    (ackB),
    .o_tx_byte  (txByte),
    .o_tx_valid (txValid),
    .o_tx_last  (txLast),
    .o_done_a   (doneA),
    .o_done_b   (doneB),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput(name, {17'h0, txValid, txLast, busy, ackA, ackB, doneA, doneB, txByte}, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushPacket(input logic owner, input logic [8*NB-1:0] pkt);
    for (int i = 0; i < NB; i++) begin
      expByte.push_back({(i == NB - 1), pkt[8*i +: 8]});
    end
    expAck.push_back(owner);
    expDone.push_back(owner);
  endtask

  // Steps until any ack appears; returns the number of cycles waited.
  task automatic awaitAck(input string name, input logic expOwner, output int n);
    n = 0;
    while (!(ackA || ackB) && n < 300) begin
      step();
      n++;
    end
    checkOutput({name, "_noTimeout"}, (n < 300), 1);
    checkOutput({name, "_owner"}, ackB, expOwner);
  endtask

  // Entered just after the first SEND cycle began (or earlier); mode 0 = take always, mode 1 = 1,0,0 pattern.
  task automatic applyStimulus(input string name, input logic owner, input int mode,
                               input int expCycles, output int ackCount);
    int k;
    k = 0;
    ackCount = 0;
    while (k < 400) begin
      step();
      k++;
      if (ackA || ackB) ackCount++;
      if (owner ? doneB : doneA) break;
      txTake = (mode == 0) ? 1'b1 : ((k % 3) == 0);
    end
    txTake = 1'b1;
    checkOutput({name, "_doneNoTimeout"}, (k < 400), 1);
    if (expCycles >= 0) checkOutput({name, "_doneCycle"}, k, expCycles);
  endtask

  always @(negedge clk) begin
    logic       a;
    logic [8:0] e;
    if (nRst) begin
      if (ackA || ackB) begin
        checkOutput("ackOneHot", {31'h0, ackA & ackB}, 0);
        checkOutput("ackExpected", (expAck.size() != 0), 1);
        if (expAck.size() != 0) begin
          a = expAck.pop_front();
          checkOutput("ackOwner", {31'h0, ackB}, {31'h0, a});
        end
      end
      if (doneA || doneB) begin
        checkOutput("doneOneHot", {31'h0, doneA & doneB}, 0);
        checkOutput("doneAfterLastTake", {31'h0, doneArmed}, 1);
        doneArmed = 1'b0;
        checkOutput("doneExpected", (expDone.size() != 0), 1);
        if (expDone.size() != 0) begin
          a = expDone.pop_front();
          checkOutput("doneOwner", {31'h0, doneB}, {31'h0, a});
        end
      end
      if (txValid) begin
        checkOutput("byteExpected", (expByte.size() != 0), 1);
        if (expByte.size() != 0) begin
          e = expByte[0];
          checkOutput("txLastByte", {23'h0, txLast, txByte}, {23'h0, e});
          if (txTake) begin
            e = expByte.pop_front();
            if (e[8]) doneArmed = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int n;
    int acks;
    logic sawDone;
    nRst   = 1'b0;
    reqA   = 1'b0;
    reqB   = 1'b0;
    pktA   = '0;
    pktB   = '0;
    txTake = 1'b0;

    #3;
    checkAllZero("resetOutputs");
    step();
    step();
    nRst = 1'b1;
    step();
    checkAllZero("idleAfterReset");

    $display("[TB] single packet from A");
    for (int i = 0; i < NB; i++) pktA[8*i +: 8] = 8'(i);
    pushPacket(1'b0, pktA);
    txTake = 1'b1;
    reqA = 1'b1;
    awaitAck("singleA_ack", 1'b0, n);
    checkOutput("singleA_ackLatency", n, 1);
    reqA = 1'b0;
    step();
    checkOutput("singleA_firstByte", {22'h0, txValid, txLast, txByte}, {22'h0, 2'b10, 8'h00});
    applyStimulus("singleA", 1'b0, 0, 66, acks);
    step();
    checkOutput("singleA_idle", {31'h0, busy}, 0);

    $display("[TB] backpressure");
    for (int i = 0; i < NB; i++) pktA[8*i +: 8] = 8'(i * 3 + 5);
    pushPacket(1'b0, pktA);
    reqA = 1'b1;
    awaitAck("bp_ack", 1'b0, n);
    reqA = 1'b0;
    step();
    applyStimulus("bp", 1'b0, 1, 196, acks);
    checkOutput("bp_allBytesTaken", expByte.size(), 0);

    $display("[TB] reset in the middle of SEND");
    step();
    for (int i = 0; i < NB; i++) pktA[8*i +: 8] = 8'(i);
    pushPacket(1'b0, pktA);
    reqA = 1'b1;
    awaitAck("midRst_ack", 1'b0, n);
    reqA = 1'b0;
    step();
    repeat (10) step();
    checkOutput("midRst_byte10", {24'h0, txByte}, 32'h0A);
    #2;
    nRst = 1'b0;
    #1;
    checkAllZero("midRst_async");
    expByte.delete();
    expAck.delete();
    expDone.delete();
    doneArmed = 1'b0;
    step();
    nRst = 1'b1;
    sawDone = 1'b0;
    repeat (4) begin
      step();
      sawDone = sawDone | doneA | doneB;
    end
    checkOutput("midRst_noDone", {31'h0, sawDone}, 0);
    checkOutput("midRst_idle", {31'h0, busy}, 0);

    $display("[TB] contention A,B,A");
    for (int i = 0; i < NB; i++) begin
      pktA[8*i +: 8] = 8'hAA;
      pktB[8*i +: 8] = 8'hBB;
    end
    pushPacket(1'b0, pktA);
    pushPacket(1'b1, pktB);
    pushPacket(1'b0, pktA);
    reqA = 1'b1;
    reqB = 1'b1;
    awaitAck("cont1", 1'b0, n);
    applyStimulus("cont1", 1'b0, 0, 67, acks);
    awaitAck("cont2", 1'b1, n);
    checkOutput("cont2_regrantGap", n, 2);
    applyStimulus("cont2", 1'b1, 0, 67, acks);
    awaitAck("cont3", 1'b0, n);
    reqA = 1'b0;
    reqB = 1'b0;
    applyStimulus("cont3", 1'b0, 0, 67, acks);

    $display("[TB] capture isolation");
    step();
    for (int i = 0; i < NB; i++) pktA[8*i +: 8] = 8'(8'h10 + i);
    pushPacket(1'b0, pktA);
    reqA = 1'b1;
    awaitAck("capture_ack", 1'b0, n);
    reqA = 1'b0;
    step();
    pktA = '1;
    applyStimulus("capture", 1'b0, 0, 66, acks);

    $display("[TB] late request from B");
    step();
    for (int i = 0; i < NB; i++) begin
      pktA[8*i +: 8] = 8'(8'h30 + i);
      pktB[8*i +: 8] = 8'(8'hC0 ^ i);
    end
    pushPacket(1'b0, pktA);
    reqA = 1'b1;
    awaitAck("late_ackA", 1'b0, n);
    reqA = 1'b0;
    repeat (5) step();
    pushPacket(1'b1, pktB);
    reqB = 1'b1;
    applyStimulus("lateA", 1'b0, 0, 62, acks);
    checkOutput("late_noAckDuringA", acks, 0);
    step();
    checkOutput("late_noAckInIdle", {31'h0, ackB}, 0);
    step();
    checkOutput("late_ackBTwoAfterDone", {31'h0, ackB}, 1);
    reqB = 1'b0;
    applyStimulus("lateB", 1'b1, 0, 67, acks);
    step();
    step();
    checkOutput("final_idle", {31'h0, busy}, 0);
    checkOutput("final_queuesEmpty", expByte.size() + expAck.size() + expDone.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
